// File: rtl/slc3_mem_pkg.sv
// Shared types and constants for the SLC-3 external SRAM access path.
package slc3_mem_pkg;

  // Largest wait-state count the 4-bit wait counter can hold.
  localparam int MAX_WAIT = 15;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } sram_state_t;

  // SRAM control strobes, all active-low.
  typedef struct packed {
    logic ce;
    logic ub;
    logic lb;
    logic oe;
    logic we;
  } strobes_t;

  localparam strobes_t STROBES_IDLE = 5'b11111;

endpackage

// File: rtl/sram_sequencer.sv
// Multi-cycle access sequencer for the external 1Mx16 SRAM: accepts one
// request, drives registered strobes for WAIT_CYCLES+1 cycles, then pulses
// rsp_valid for one cycle (holding write data through that cycle).
module sram_sequencer
  import slc3_mem_pkg::*;
#(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_be,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              CE,
  output logic              UB,
  output logic              LB,
  output logic              OE,
  output logic              WE,
  output logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] Data_write,
  input  logic [DATA_W-1:0] Data_read,
  output logic              Data_oe
);

  // Elaboration guards: the counter is 4 bits and the lane logic is 2x8.
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > MAX_WAIT) begin : g_bad_wait
    $error("sram_sequencer: WAIT_CYCLES must be in 0..15");
  end
  if (DATA_W != 16) begin : g_bad_width
    $error("sram_sequencer: only DATA_W=16 is supported");
  end

  sram_state_t       state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        be_q, be_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  strobes_t          strobes_q, strobes_d;
  logic              data_oe_q, data_oe_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rd_masked;

  // Disabled byte lanes read back as 0x00.
  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    assign rd_masked[gi*8 +: 8] = be_q[gi] ? Data_read[gi*8 +: 8] : 8'h00;
  end

  assign req_ready = (state_q == IDLE) & ~Reset;

  // Next state, request capture, and next values of the registered pins.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    rdata_d     = rdata_q;
    strobes_d   = STROBES_IDLE;
    data_oe_d   = 1'b0;
    rsp_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          state_d = ACCESS;
          cnt_d   = 4'(WAIT_CYCLES);
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          if (!we_q) begin
            rdata_d = rd_masked;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Pins are registered from the state being entered so they change
    // only on clock edges.
    if (state_d == ACCESS) begin
      strobes_d.ce = 1'b0;
      strobes_d.ub = ~be_d[1];
      strobes_d.lb = ~be_d[0];
      if (we_d) begin
        strobes_d.oe = 1'b1;
        strobes_d.we = (be_d == 2'b00);
        data_oe_d    = 1'b1;
      end else begin
        strobes_d.oe = 1'b0;
        strobes_d.we = 1'b1;
      end
    end else if (state_d == DONE) begin
      rsp_valid_d = 1'b1;
      data_oe_d   = we_d;
    end
  end

  // State and pin registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= 2'b00;
      rdata_q     <= '0;
      strobes_q   <= STROBES_IDLE;
      data_oe_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      rdata_q     <= rdata_d;
      strobes_q   <= strobes_d;
      data_oe_q   <= data_oe_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign CE         = strobes_q.ce;
  assign UB         = strobes_q.ub;
  assign LB         = strobes_q.lb;
  assign OE         = strobes_q.oe;
  assign WE         = strobes_q.we;
  assign ADDR       = addr_q;
  assign Data_write = wdata_q;
  assign Data_oe    = data_oe_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rdata_q;

endmodule

// File: tb/tb_sram_sequencer.sv
// Bench for sram_sequencer: one instance with WAIT_CYCLES=2 (a) and one with
// WAIT_CYCLES=0 (b), each attached to a small SRAM model.
module tb_sram_sequencer;

  logic clk = 1'b0;
  logic Reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- instance a (WAIT_CYCLES=2) ----------------
  logic        req_valid_a, req_ready_a, req_we_a, rsp_valid_a;
  logic [19:0] req_addr_a, ADDR_a;
  logic [15:0] req_wdata_a, rsp_rdata_a, Data_write_a, Data_read_a;
  logic [1:0]  req_be_a;
  logic        CE_a, UB_a, LB_a, OE_a, WE_a, Data_oe_a;

  sram_sequencer #(.ADDR_W(20), .DATA_W(16), .WAIT_CYCLES(2)) dut_a (
    .Clk(clk), .Reset(Reset),
    .req_valid(req_valid_a), .req_ready(req_ready_a), .req_we(req_we_a),
    .req_addr(req_addr_a), .req_wdata(req_wdata_a), .req_be(req_be_a),
    .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a),
    .CE(CE_a), .UB(UB_a), .LB(LB_a), .OE(OE_a), .WE(WE_a),
    .ADDR(ADDR_a), .Data_write(Data_write_a), .Data_read(Data_read_a),
    .Data_oe(Data_oe_a)
  );

  // ---------------- instance b (WAIT_CYCLES=0) ----------------
  logic        req_valid_b, req_ready_b, req_we_b, rsp_valid_b;
  logic [19:0] req_addr_b, ADDR_b;
  logic [15:0] req_wdata_b, rsp_rdata_b, Data_write_b, Data_read_b;
  logic [1:0]  req_be_b;
  logic        CE_b, UB_b, LB_b, OE_b, WE_b, Data_oe_b;

  sram_sequencer #(.ADDR_W(20), .DATA_W(16), .WAIT_CYCLES(0)) dut_b (
    .Clk(clk), .Reset(Reset),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_we(req_we_b),
    .req_addr(req_addr_b), .req_wdata(req_wdata_b), .req_be(req_be_b),
    .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b),
    .CE(CE_b), .UB(UB_b), .LB(LB_b), .OE(OE_b), .WE(WE_b),
    .ADDR(ADDR_b), .Data_write(Data_write_b), .Data_read(Data_read_b),
    .Data_oe(Data_oe_b)
  );

  // ---------------- SRAM models ----------------
  logic [15:0] mem_a [0:1023];
  logic [15:0] mem_b [0:1023];

  assign Data_read_a = (!CE_a && !OE_a) ? mem_a[ADDR_a[9:0]] : 16'h0000;
  assign Data_read_b = (!CE_b && !OE_b) ? mem_b[ADDR_b[9:0]] : 16'h0000;

  always @(posedge clk) begin
    if (!CE_a && !WE_a && Data_oe_a) begin
      if (!UB_a) mem_a[ADDR_a[9:0]][15:8] <= Data_write_a[15:8];
      if (!LB_a) mem_a[ADDR_a[9:0]][7:0]  <= Data_write_a[7:0];
    end
    if (!CE_b && !WE_b && Data_oe_b) begin
      if (!UB_b) mem_b[ADDR_b[9:0]][15:8] <= Data_write_b[15:8];
      if (!LB_b) mem_b[ADDR_b[9:0]][7:0]  <= Data_write_b[7:0];
    end
  end

  // ---------------- scoreboards and monitors ----------------
  logic [15:0] qa[$];
  logic [15:0] qb[$];
  int acc_a = 0, acc_b = 0, iss_a = 0, iss_b = 0;
  bit we_low_b = 1'b0;

  always @(posedge clk) begin
    if (req_valid_a && req_ready_a) acc_a <= acc_a + 1;
    if (req_valid_b && req_ready_b) acc_b <= acc_b + 1;
  end

  // Each response pops one expected rsp_rdata (for writes: the unchanged
  // value from the previous read).
  always @(negedge clk) begin
    if (rsp_valid_a) begin
      if (qa.size() == 0) check("rsp_a_unexpected", 32'd1, 32'd0);
      else check("rsp_rdata_a", {16'h0, rsp_rdata_a}, {16'h0, qa.pop_front()});
    end
    if (rsp_valid_b) begin
      if (qb.size() == 0) check("rsp_b_unexpected", 32'd1, 32'd0);
      else check("rsp_rdata_b", {16'h0, rsp_rdata_b}, {16'h0, qb.pop_front()});
    end
    if (!WE_b) we_low_b = 1'b1;
  end

  function automatic logic [6:0] pins(input bit sel);
    if (sel) return {CE_b, UB_b, LB_b, OE_b, WE_b, Data_oe_b, rsp_valid_b};
    return {CE_a, UB_a, LB_a, OE_a, WE_a, Data_oe_a, rsp_valid_a};
  endfunction

  // Drive a request at a falling edge and return at the falling edge just
  // after the accepting rising edge (first ACCESS cycle).
  task automatic issue(input bit sel, input bit we, input logic [19:0] addr,
                       input logic [15:0] wdata, input logic [1:0] be,
                       input bit push, input logic [15:0] exp, output int acc_cyc);
    bit ok = 1'b0;
    @(negedge clk);
    if (sel) begin
      req_valid_b = 1'b1; req_we_b = we; req_addr_b = addr; req_wdata_b = wdata; req_be_b = be;
    end else begin
      req_valid_a = 1'b1; req_we_a = we; req_addr_a = addr; req_wdata_a = wdata; req_be_a = be;
    end
    for (int i = 0; i < 50; i++) begin
      if (sel ? req_ready_b : req_ready_a) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      $display("FAIL accept_timeout: got no accept expected accept");
      n_fail++;
    end
    if (push) begin
      if (sel) qb.push_back(exp); else qa.push_back(exp);
    end
    if (sel) iss_b++; else iss_a++;
    acc_cyc = cyc;
    @(posedge clk);
    @(negedge clk);
    if (sel) req_valid_b = 1'b0; else req_valid_a = 1'b0;
  endtask

  // Check pins through the ACCESS phase and the DONE cycle; returns at the
  // first IDLE falling edge.
  task automatic run_access(input bit sel, input int w, input bit we,
                            input logic [1:0] be, input logic [19:0] addr,
                            input logic [15:0] wdata, input string tag);
    logic [6:0] exp_acc;
    exp_acc = {1'b0, ~be[1], ~be[0], we, ~(we && be != 2'b00), we, 1'b0};
    for (int k = 0; k <= w; k++) begin
      check({tag, "_access_pins"}, {25'h0, pins(sel)}, {25'h0, exp_acc});
      check({tag, "_addr"}, {12'h0, sel ? ADDR_b : ADDR_a}, {12'h0, addr});
      if (we) check({tag, "_wdata"}, {16'h0, sel ? Data_write_b : Data_write_a}, {16'h0, wdata});
      @(negedge clk);
    end
    check({tag, "_done_pins"}, {25'h0, pins(sel)}, {25'h0, 5'b11111, we, 1'b1});
    if (we) check({tag, "_done_hold"}, {16'h0, sel ? Data_write_b : Data_write_a}, {16'h0, wdata});
    @(negedge clk);
    check({tag, "_ready_back"}, {31'h0, sel ? req_ready_b : req_ready_a}, 32'd1);
  endtask

  int t, acc_t[3];
  logic [19:0] bb_addr[3];
  logic [15:0] bb_data[3];
  int n;

  initial begin
    for (int i = 0; i < 1024; i++) begin mem_a[i] = 16'h0; mem_b[i] = 16'h0; end
    mem_a[10'h01A] = 16'hBEEF;
    mem_a[10'h040] = 16'hAAAA;
    mem_a[10'h050] = 16'h1111;
    mem_a[10'h051] = 16'h2222;
    mem_a[10'h052] = 16'h3333;
    mem_b[10'h010] = 16'hFFFF;
    mem_b[10'h011] = 16'h4242;
    req_valid_a = 0; req_we_a = 0; req_addr_a = 0; req_wdata_a = 0; req_be_a = 0;
    req_valid_b = 0; req_we_b = 0; req_addr_b = 0; req_wdata_b = 0; req_be_b = 0;
    Reset = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state.
    check("reset_pins_a", {25'h0, pins(1'b0)}, {25'h0, 7'b1111100});
    check("reset_addr_a", {12'h0, ADDR_a}, 32'h0);
    check("reset_wdata_a", {16'h0, Data_write_a}, 32'h0);
    check("reset_rdata_a", {16'h0, rsp_rdata_a}, 32'h0);
    check("reset_ready_a", {31'h0, req_ready_a}, 32'd0);
    Reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset_a", {31'h0, req_ready_a}, 32'd1);

    // Full-word read.
    issue(1'b0, 1'b0, 20'h0001A, 16'h0, 2'b11, 1'b1, 16'hBEEF, t);
    run_access(1'b0, 2, 1'b0, 2'b11, 20'h0001A, 16'h0, "rd1");

    // Full-word write and read-back.
    issue(1'b0, 1'b1, 20'h00300, 16'h1234, 2'b11, 1'b1, 16'hBEEF, t);
    run_access(1'b0, 2, 1'b1, 2'b11, 20'h00300, 16'h1234, "wr1");
    check("mem_300", {16'h0, mem_a[10'h300]}, 32'h1234);
    issue(1'b0, 1'b0, 20'h00300, 16'h0, 2'b11, 1'b1, 16'h1234, t);
    run_access(1'b0, 2, 1'b0, 2'b11, 20'h00300, 16'h0, "rd2");

    // Byte lanes: lower-byte write, upper-byte read.
    issue(1'b0, 1'b1, 20'h00040, 16'h55CC, 2'b01, 1'b1, 16'h1234, t);
    run_access(1'b0, 2, 1'b1, 2'b01, 20'h00040, 16'h55CC, "wr_lo");
    check("mem_40", {16'h0, mem_a[10'h040]}, 32'hAACC);
    issue(1'b0, 1'b0, 20'h00040, 16'h0, 2'b10, 1'b1, 16'hAA00, t);
    run_access(1'b0, 2, 1'b0, 2'b10, 20'h00040, 16'h0, "rd_hi");

    // Back-to-back reads with req_valid held high.
    bb_addr[0] = 20'h00050; bb_addr[1] = 20'h00051; bb_addr[2] = 20'h00052;
    bb_data[0] = 16'h1111;  bb_data[1] = 16'h2222;  bb_data[2] = 16'h3333;
    n = 0;
    @(negedge clk);
    req_valid_a = 1'b1; req_we_a = 1'b0; req_be_a = 2'b11; req_addr_a = bb_addr[0];
    qa.push_back(bb_data[0]); iss_a++;
    for (int c = 0; c < 60 && n < 3; c++) begin
      if (req_ready_a) begin
        acc_t[n] = cyc;
        n++;
        @(negedge clk);
        if (n < 3) begin
          req_addr_a = bb_addr[n];
          qa.push_back(bb_data[n]); iss_a++;
        end else begin
          req_valid_a = 1'b0;
        end
      end else begin
        @(negedge clk);
      end
    end
    check("b2b_accepts", n, 3);
    check("b2b_gap1", acc_t[1] - acc_t[0], 5);
    check("b2b_gap2", acc_t[2] - acc_t[1], 5);
    repeat (6) @(negedge clk);
    check("b2b_queue_drained", qa.size(), 0);

    // Reset during the second ACCESS cycle of a write: no response expected.
    issue(1'b0, 1'b1, 20'h00060, 16'h9999, 2'b11, 1'b0, 16'h0, t);
    @(negedge clk);
    check("mid_wr_we_low", {31'h0, WE_a}, 32'd0);
    Reset = 1'b1;
    @(negedge clk);
    check("abort_pins", {25'h0, pins(1'b0)}, {25'h0, 7'b1111100});
    check("abort_ready", {31'h0, req_ready_a}, 32'd0);
    Reset = 1'b0;
    @(negedge clk);
    check("abort_ready_back", {31'h0, req_ready_a}, 32'd1);
    check("abort_rdata_cleared", {16'h0, rsp_rdata_a}, 32'h0);
    repeat (4) @(negedge clk);

    // WAIT_CYCLES=0, no byte enables: read returns zero, write never drops WE.
    issue(1'b1, 1'b0, 20'h00010, 16'h0, 2'b00, 1'b1, 16'h0000, t);
    run_access(1'b1, 0, 1'b0, 2'b00, 20'h00010, 16'h0, "b_rd00");
    issue(1'b1, 1'b1, 20'h00011, 16'h7777, 2'b00, 1'b1, 16'h0000, t);
    run_access(1'b1, 0, 1'b1, 2'b00, 20'h00011, 16'h7777, "b_wr00");
    check("b_mem_11", {16'h0, mem_b[10'h011]}, 32'h4242);
    check("b_we_never_low", {31'h0, we_low_b}, 32'd0);

    // WAIT_CYCLES=0 full read for latency sanity.
    issue(1'b1, 1'b0, 20'h00010, 16'h0, 2'b11, 1'b1, 16'hFFFF, t);
    run_access(1'b1, 0, 1'b0, 2'b11, 20'h00010, 16'h0, "b_rd11");

    repeat (3) @(negedge clk);
    check("accept_count_a", acc_a, iss_a);
    check("accept_count_b", acc_b, iss_b);
    check("queue_a_empty", qa.size(), 0);
    check("queue_b_empty", qb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
